// File: rtl/lfsr_period_mon.sv
// Period monitor for the 4-bit LFSR stage: measures cycles until the first captured word recurs.
// Optional MSB-set sample counter is built only when LFSR_MON_ONES_EN is defined.
//
// state    | meaning
// S_IDLE   | waiting for start, results held
// S_ARM    | capture reference sample, detect all-zero lock-up
// S_MEAS   | compare each sample against reference, count cycles
// S_REPORT | one-cycle done pulse, results valid
module lfsr_period_mon #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             res,
   input  logic             start,
   input  logic             clear,
   input  logic [WIDTH-1:0] lfsr_in,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] period,
   output logic             lockup,
   output logic             timeout,
   output logic [CNT_W-1:0] ones_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEAS, S_REPORT} state_t;

   localparam logic [CNT_W-1:0] MAXP = '1;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   ref_q, ref_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   period_q, period_d;
   logic               lockup_q, lockup_d;
   logic               timeout_q, timeout_d;
   logic [CNT_W-1:0]   cnt_inc;
   logic               match;

   assign cnt_inc = cnt_q + CNT_W'(1);
   assign match   = (lfsr_in == ref_q);

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:   if (start) state_d = S_ARM;
            S_ARM:    state_d = (lfsr_in == '0) ? S_REPORT : S_MEAS;
            S_MEAS:   if (match || (cnt_inc == MAXP)) state_d = S_REPORT;
            S_REPORT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      busy = (state_q == S_ARM) || (state_q == S_MEAS);
      done = (state_q == S_REPORT);
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         ref_q     <= '0;
         cnt_q     <= '0;
         period_q  <= '0;
         lockup_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         ref_q     <= ref_d;
         cnt_q     <= cnt_d;
         period_q  <= period_d;
         lockup_q  <= lockup_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      ref_d     = ref_q;
      cnt_d     = cnt_q;
      period_d  = period_q;
      lockup_d  = lockup_q;
      timeout_d = timeout_q;
      if (clear) begin
         ref_d     = '0;
         cnt_d     = '0;
         period_d  = '0;
         lockup_d  = 1'b0;
         timeout_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  period_d  = '0;
                  lockup_d  = 1'b0;
                  timeout_d = 1'b0;
               end
            end
            S_ARM: begin
               ref_d = lfsr_in;
               cnt_d = '0;
               if (lfsr_in == '0) begin
                  lockup_d = 1'b1;
                  period_d = '0;
               end
            end
            S_MEAS: begin
               // A recurrence on the final allowed cycle still reports a real period.
               if (match) begin
                  period_d = cnt_inc;
               end else if (cnt_inc == MAXP) begin
                  timeout_d = 1'b1;
                  period_d  = MAXP;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            default: ;
         endcase
      end
   end

   assign period  = period_q;
   assign lockup  = lockup_q;
   assign timeout = timeout_q;

`ifdef LFSR_MON_ONES_EN
   logic [CNT_W-1:0] ones_q, ones_d;

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         ones_q <= '0;
      end else begin
         ones_q <= ones_d;
      end
   end

   always_comb begin
      ones_d = ones_q;
      if (clear) begin
         ones_d = '0;
      end else begin
         case (state_q)
            S_IDLE:  if (start) ones_d = '0;
            S_ARM:   ones_d = '0;
            S_MEAS:  if (lfsr_in[WIDTH-1]) ones_d = ones_q + CNT_W'(1);
            default: ;
         endcase
      end
   end

   assign ones_cnt = ones_q;
`else
   assign ones_cnt = '0;
`endif

endmodule

// File: doc/lfsr_period_mon.md
Name: lfsr_period_mon

Overview:
- Downstream consumer of the 4-bit LFSR stage.
- Samples the LFSR output word every clock and measures the sequence period: the number of cycles until the first captured value recurs.
- Flags the all-zero lock-up state and a timeout if no recurrence is seen within the counter range.
- Results are held in registers for the self-test/status logic that reads them after a seed load.

Parameters:
- WIDTH, 4: width of the sampled LFSR word.
- CNT_W, 8: width of the period counter. Measurement limit is MAXP = 2^CNT_W - 1 cycles.

Ports:
- clk  in  1  system clock, rising edge.
- res  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a measurement. Honoured only in IDLE.
- clear  in  1  synchronous abort/clear. Returns to IDLE and zeroes all result outputs.
- lfsr_in  in  WIDTH  LFSR output word, sampled every rising edge.
- busy  out  1  high in ARM and MEASURE.
- done  out  1  one-cycle pulse in REPORT.
- period  out  CNT_W  measured period.
- lockup  out  1  reference sample was all-zero.
- timeout  out  1  no recurrence within MAXP cycles.
- ones_cnt  out  CNT_W  count of samples with MSB set over the measured period (optional feature).

Behaviour:
- Reset (res=0, asynchronous): state=IDLE. busy, done, period, lockup, timeout, ones_cnt, internal ref and cnt all 0.
- States: IDLE, ARM, MEASURE, REPORT (registered FSM).
- IDLE:
  - busy=0.
  - start=1 -> ARM. The result outputs period, lockup, timeout and ones_cnt are cleared on this transition.
- ARM (1 cycle):
  - ref <= lfsr_in (sample s0); cnt <= 0.
  - If lfsr_in==0: lockup<=1, period<=0 -> REPORT.
  - Otherwise -> MEASURE.
- MEASURE, cycle k = 1, 2, ... (cnt holds k-1 on entry, sample s_k is compared):
  - lfsr_in==ref: period<=cnt+1 -> REPORT.
  - Else if cnt+1==MAXP: timeout<=1, period<=MAXP -> REPORT.
  - Else cnt<=cnt+1 -> stay.
  - Recurrence takes priority over timeout in the same cycle.
- REPORT (1 cycle):
  - done=1 -> IDLE.
  - Results stay stable until the next accepted start, a clear, or a reset.
- Latency: done asserts P+2 cycles after the start cycle for period P; 2 cycles for lock-up.
- start outside IDLE is ignored, with no restart and no queuing.
- clear=1 in any state -> IDLE next edge, all outputs 0. clear beats start in the same cycle.
- An all-zero sample that appears in MEASURE after a non-zero ref is not a lock-up. It is treated as an ordinary non-matching sample.
- Reset mid-measurement aborts immediately with no done pulse.
- cnt never wraps; the timeout check prevents overflow.

Optional Feature:
- Macro: LFSR_MON_ONES_EN.
- Defined:
  - In MEASURE, each sample s_k with lfsr_in[WIDTH-1]=1 increments ones_cnt, including the matching sample s_P.
  - ones_cnt is cleared in ARM and is valid with done.
  - On timeout it covers s_1..s_MAXP.
- Undefined: ones_cnt is tied to 0 and no counter logic is synthesised. The port stays present.

Test Plan:
1. Reset mid-measurement: start, then res=0 during MEASURE -> all outputs 0 immediately, no done pulse. After res=1, IDLE, and a new start is accepted.
2. Lock-up: lfsr_in held at 4'h0, start pulse -> done 2 cycles later, lockup=1, period=0, timeout=0.
3. Constant input: lfsr_in held at 4'h5, start -> period=1, lockup=0, done at start+3.
4. Maximal sequence: drive a 15-state sequence of all non-zero values starting at 4'h9 -> period=15, done at start+17. With LFSR_MON_ONES_EN, ones_cnt=8.
5. Timeout: CNT_W=3 with the same 15-state sequence -> timeout=1, period=7, done after 7 MEASURE cycles.
6. Ignored start and clear: a second start pulse during MEASURE does not change period=15. Then start again and assert clear at k=4 -> IDLE, outputs 0, no done pulse.
